// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants and the next-PC select encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF    = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam int unsigned INC_DEF       = 4;
    localparam int unsigned RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_HOLD,
        NPC_RET,
        NPC_JMP,
        NPC_BR,
        NPC_EXC
    } npc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push while full silently replaces the oldest entry.
module ras_stack #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] data_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overflow_o
);

    localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              wr_en;
    logic [PtrW-1:0]   wr_idx;
    logic              pop_eff;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CntW'(RAS_DEPTH));
    assign overflow_o = ovf_q;
    assign top_o      = mem_q[ptr_q];

    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        pop_eff = pop_i && !empty_o;
        if (flush_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push_i && pop_eff) begin
            // Pop-then-push collapses to overwriting the current top in place.
            wr_en = 1'b1;
        end else if (push_i) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q + PtrW'(1);
            ptr_d  = wr_idx;
            if (full_o) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (pop_eff) begin
            ptr_d = ptr_q - PtrW'(1);
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: prioritised next-PC mux, PC register and RAS for call/return.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
    parameter int unsigned       INC       = INC_DEF,
    parameter int unsigned       RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              stall_i,
    input  logic              exception_i,
    input  logic [ADDR_W-1:0] exc_vector_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic              call_i,
    input  logic [ADDR_W-1:0] ret_addr_i,
    input  logic              return_i,
    input  logic [ADDR_W-1:0] return_target_i,
    output logic [ADDR_W-1:0] pc_result_o,
    output logic [ADDR_W-1:0] pc_plus_o,
    output logic              pc_valid_o,
    output logic              ras_empty_o,
    output logic              ras_full_o,
    output logic              ras_overflow_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q;
    logic [ADDR_W-1:0] ras_top;
    logic              id_accept;
    logic              ras_push;
    logic              ras_pop;
    logic              ras_flush;
    npc_sel_e          npc_sel;

    assign pc_result_o = pc_q;
    assign pc_plus_o   = pc_q + ADDR_W'(INC);
    assign pc_valid_o  = valid_q;

    // ID-stage requests only take effect when nothing upstream of them in priority is active.
    assign id_accept = !reset_i && !exception_i && !branch_taken_i && !stall_i;
    assign ras_push  = id_accept && jump_i && call_i;
    assign ras_pop   = id_accept && return_i;
    assign ras_flush = !reset_i && exception_i;

    always_comb begin
        npc_sel = NPC_SEQ;
        if (exception_i) begin
            npc_sel = NPC_EXC;
        end else if (branch_taken_i) begin
            npc_sel = NPC_BR;
        end else if (stall_i) begin
            npc_sel = NPC_HOLD;
        end else if (jump_i) begin
            npc_sel = NPC_JMP;
        end else if (return_i) begin
            npc_sel = NPC_RET;
        end
    end

    always_comb begin
        pc_d = pc_plus_o;
        unique case (npc_sel)
            NPC_EXC:  pc_d = exc_vector_i;
            NPC_BR:   pc_d = branch_target_i;
            NPC_JMP:  pc_d = jump_target_i;
            NPC_RET:  pc_d = ras_empty_o ? return_target_i : ras_top;
            NPC_HOLD: pc_d = pc_q;
            default:  pc_d = pc_plus_o;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
        end
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .push_i     (ras_push),
        .pop_i      (ras_pop),
        .flush_i    (ras_flush),
        .data_i     (ret_addr_i),
        .top_o      (ras_top),
        .empty_o    (ras_empty_o),
        .full_o     (ras_full_o),
        .overflow_o (ras_overflow_o)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: queue-based reference model checked every cycle plus literal pins.
module tb_pc_unit;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset, stall, exc, br, jmp, call, ret;
    logic [AW-1:0] exc_vec, br_tgt, jmp_tgt, ret_addr, ret_tgt;
    logic [AW-1:0] pc, pc_plus;
    logic          pc_valid, ras_empty, ras_full, ras_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [AW-1:0] m_pc;
    logic          m_valid;
    logic          m_ovf;
    logic [AW-1:0] m_ras[$];
    logic          started = 1'b0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .stall_i         (stall),
        .exception_i     (exc),
        .exc_vector_i    (exc_vec),
        .branch_taken_i  (br),
        .branch_target_i (br_tgt),
        .jump_i          (jmp),
        .jump_target_i   (jmp_tgt),
        .call_i          (call),
        .ret_addr_i      (ret_addr),
        .return_i        (ret),
        .return_target_i (ret_tgt),
        .pc_result_o     (pc),
        .pc_plus_o       (pc_plus),
        .pc_valid_o      (pc_valid),
        .ras_empty_o     (ras_empty),
        .ras_full_o      (ras_full),
        .ras_overflow_o  (ras_ovf)
    );

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Model: inputs are stable at the rising edge, so sample them there.
    initial forever begin
        @(posedge clk);
        started = 1'b1;
        if (reset) begin
            m_pc = 32'h0; m_valid = 1'b0; m_ovf = 1'b0; m_ras.delete();
        end else begin
            m_valid = 1'b1;
            if (exc) begin
                m_pc = exc_vec; m_ras.delete();
            end else if (br) begin
                m_pc = br_tgt;
            end else if (stall) begin
                m_pc = m_pc;
            end else if (jmp) begin
                m_pc = jmp_tgt;
                if (call) begin
                    if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
                    m_ras.push_back(ret_addr);
                    if (m_ras.size() > DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                end else if (ret && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end else if (ret) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else m_pc = ret_tgt;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // Compare every cycle on the falling edge.
    initial forever begin
        @(negedge clk);
        if (started) begin
            check("m_pc",    pc,                 m_pc);
            check("m_plus",  pc_plus,            m_pc + 32'd4);
            check("m_valid", {31'b0, pc_valid},  {31'b0, m_valid});
            check("m_empty", {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
            check("m_full",  {31'b0, ras_full},  {31'b0, m_ras.size() == DEPTH});
            check("m_ovf",   {31'b0, ras_ovf},   {31'b0, m_ovf});
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        stall = 0; exc = 0; br = 0; jmp = 0; call = 0; ret = 0;
    endtask

    task automatic do_call(input logic [AW-1:0] tgt, input logic [AW-1:0] ra);
        idle(); jmp = 1; call = 1; jmp_tgt = tgt; ret_addr = ra;
        tick();
    endtask

    task automatic do_ret(input logic [AW-1:0] rt);
        idle(); ret = 1; ret_tgt = rt;
        tick();
    endtask

    initial begin
        idle();
        reset = 1; exc_vec = '0; br_tgt = '0; jmp_tgt = '0; ret_addr = '0; ret_tgt = '0;
        tick(); tick();
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'b0, pc_valid}, 32'd0);
        check("rst_empty", {31'b0, ras_empty}, 32'd1);

        reset = 0;
        tick(); check("seq_4", pc, 32'h4);
        check("seq_valid", {31'b0, pc_valid}, 32'd1);
        tick(); check("seq_8", pc, 32'h8);
        check("plus_c", pc_plus, 32'hC);

        stall = 1;
        tick(); tick(); tick();
        check("stall_hold", pc, 32'h8);
        br = 1; br_tgt = 32'h40;
        tick(); check("br_over_stall", pc, 32'h40);
        idle();
        tick(); check("after_br", pc, 32'h44);

        do_call(32'h300, 32'h33);
        exc = 1; exc_vec = 32'h80; br = 1; jmp = 1; jmp_tgt = 32'h20; call = 0;
        tick(); check("exc_prio", pc, 32'h80);
        check("exc_flush", {31'b0, ras_empty}, 32'd1);

        do_call(32'h100, 32'h14);
        check("call_pc", pc, 32'h100);
        idle(); stall = 1; ret = 1; ret_tgt = 32'h999;
        tick(); check("stall_ret_ign", pc, 32'h100);
        do_ret(32'h999); check("ret_pc", pc, 32'h14);
        check("ret_empty", {31'b0, ras_empty}, 32'd1);
        do_ret(32'h200); check("ret_rf", pc, 32'h200);

        do_call(32'h1000, 32'h10);
        do_call(32'h1000, 32'h20);
        do_call(32'h1000, 32'h30);
        do_call(32'h1000, 32'h40);
        do_call(32'h1000, 32'h50);
        check("ovf_full", {31'b0, ras_full}, 32'd1);
        check("ovf_flag", {31'b0, ras_ovf}, 32'd1);
        do_ret(32'h0); check("pop_50", pc, 32'h50);
        do_ret(32'h0); check("pop_40", pc, 32'h40);
        do_ret(32'h0); check("pop_30", pc, 32'h30);
        do_ret(32'h0); check("pop_20", pc, 32'h20);
        check("pop_empty", {31'b0, ras_empty}, 32'd1);

        do_call(32'h400, 32'h60);
        idle(); jmp = 1; call = 1; ret = 1; jmp_tgt = 32'h500; ret_addr = 32'h70;
        tick(); check("callret_pc", pc, 32'h500);
        do_ret(32'h0); check("callret_top", pc, 32'h70);
        check("callret_empty", {31'b0, ras_empty}, 32'd1);

        idle(); jmp = 1; jmp_tgt = 32'hFFFF_FFF8;
        tick(); idle();
        tick(); check("wrap_fffc", pc, 32'hFFFF_FFFC);
        check("wrap_plus", pc_plus, 32'h0);
        tick(); check("wrap_0", pc, 32'h0);
        check("ovf_sticky", {31'b0, ras_ovf}, 32'd1);

        reset = 1; jmp = 1; jmp_tgt = 32'h700;
        tick(); check("rst_jmp_pc", pc, 32'h0);
        check("rst_ovf", {31'b0, ras_ovf}, 32'd0);
        check("rst_valid2", {31'b0, pc_valid}, 32'd0);
        reset = 0; idle();
        tick(); check("post_rst", pc, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
